march_controller: RTL and testbench

- Sequencer that runs a March C- test on the single-port RAM in the MBIST datapath.
- Generates address, write data, write enable and expected data for every March operation.
- Compares RAM read data against expected data and reports the first failing address and a saturating error count.
- Sits between the top-level test-mode logic and the RAM address/data muxes.
- Owns the mux select, asserting it only while a test is running.

---
 rtl/mbist_pkg.sv | 48 ++++
 rtl/march_addr_gen.sv | 39 +++
 rtl/march_controller.sv | 193 +++++++++++++++++++
 tb/tb_march_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared MBIST types: March C- state encoding and element table.
// Each element is described by direction, ops and data polarity.
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN
  } march_state_t;

  // up: ascending order; rd/wr: ops per address; *inv: use ~bg
  typedef struct packed {
    logic up;
    logic rd;
    logic wr;
    logic rinv;
    logic winv;
  } elem_t;

  localparam elem_t EL_M0 = 5'b10100;
  localparam elem_t EL_M1 = 5'b11101;
  localparam elem_t EL_M2 = 5'b11110;
  localparam elem_t EL_M3 = 5'b01101;
  localparam elem_t EL_M4 = 5'b01110;
  localparam elem_t EL_M5 = 5'b11000;
  localparam elem_t EL_NONE = 5'b10000;

  function automatic elem_t elem_of(march_state_t s);
    elem_t r;
    r = EL_NONE;
    unique case (s)
      ST_M0: r = EL_M0;
      ST_M1: r = EL_M1;
      ST_M2: r = EL_M2;
      ST_M3: r = EL_M3;
      ST_M4: r = EL_M4;
      ST_M5: r = EL_M5;
      ST_IDLE, ST_DRAIN: r = EL_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for the March sequencer.
// last_o flags the final address in the current direction.
module march_addr_gen #(
  parameter int size = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [size-1:0] load_val_i,
  input  logic            step_i,
  input  logic            up_i,
  output logic [size-1:0] addr_o,
  output logic            last_o
);

  logic [size-1:0] addr_q;
  logic [size-1:0] addr_d;

  // Load wins over step; otherwise hold.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      addr_d = up_i ? addr_q + size'(1)
                    : addr_q - size'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign last_o = up_i ? (&addr_q) : ~(|addr_q);

endmodule

// File: rtl/march_controller.sv
// March C- sequencer: drives RAM ops and checks read data.
// Outputs are registered from the next-op decode below.
module march_controller
  import mbist_pkg::*;
#(
  parameter int size   = 6,
  parameter int length = 8,
  parameter int cnt_w  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [length-1:0] bg,
  input  logic [length-1:0] ramout,
  output logic              NbarT,
  output logic [size-1:0]   mem_addr,
  output logic [length-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [size-1:0]   fail_addr,
  output logic [cnt_w-1:0]  fail_cnt
);

  march_state_t      state_q, state_d, nxt;
  elem_t             cur, nel;
  logic              phase_q, phase_d;
  logic              we_q, we_d;
  logic [length-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic [length-1:0] rexp_q, rexp_d;
  logic              busy_q, busy_d;
  logic              nbart_q;
  logic [length-1:0] bg_q;
  logic              cmp_q;
  logic [length-1:0] exp_q;
  logic [size-1:0]   exp_addr_q;
  logic              done_q, fail_q;
  logic [size-1:0]   fail_addr_q;
  logic [cnt_w-1:0]  fail_cnt_q;
  logic              ag_load, ag_step, last;
  logic [size-1:0]   ag_val;
  logic              kill, go;

  function automatic logic [length-1:0] pat(
    logic inv, logic [length-1:0] b);
    return inv ? ~b : b;
  endfunction

  march_addr_gen #(.size(size)) u_ag (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ag_load),
    .load_val_i(ag_val),
    .step_i    (ag_step),
    .up_i      (cur.up),
    .addr_o    (mem_addr),
    .last_o    (last)
  );

  assign cur  = elem_of(state_q);
  assign nxt  = march_state_t'(state_q + 3'd1);
  assign nel  = elem_of(nxt);
  assign kill = abort && (state_q != ST_IDLE);
  assign go   = (state_q == ST_IDLE) && start && !abort;

  // Decode the op to present next cycle.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    we_d    = 1'b0;
    wdata_d = '0;
    rd_d    = 1'b0;
    rexp_d  = '0;
    busy_d  = busy_q;
    ag_load = 1'b0;
    ag_val  = '0;
    ag_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_M0;
          ag_load = 1'b1;
          we_d    = 1'b1;
          wdata_d = bg;
          busy_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        busy_d = 1'b1;
        if (cur.rd && cur.wr && !phase_q) begin
          phase_d = 1'b1;
          we_d    = 1'b1;
          wdata_d = pat(cur.winv, bg_q);
        end else if (!last) begin
          ag_step = 1'b1;
          if (cur.rd) begin
            rd_d   = 1'b1;
            rexp_d = pat(cur.rinv, bg_q);
          end else begin
            we_d    = 1'b1;
            wdata_d = pat(cur.winv, bg_q);
          end
        end else if (state_q == ST_M5) begin
          state_d = ST_DRAIN;
          ag_load = 1'b1;
        end else begin
          state_d = nxt;
          ag_load = 1'b1;
          ag_val  = nel.up ? '0 : '1;
          rd_d    = 1'b1;
          rexp_d  = pat(nel.rinv, bg_q);
        end
      end
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      phase_d = 1'b0;
      we_d    = 1'b0;
      wdata_d = '0;
      rd_d    = 1'b0;
      busy_d  = 1'b0;
      ag_load = 1'b1;
      ag_val  = '0;
      ag_step = 1'b0;
    end
  end

  // FSM, registered outputs and compare pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      rexp_q      <= '0;
      busy_q      <= 1'b0;
      nbart_q     <= 1'b0;
      bg_q        <= '0;
      cmp_q       <= 1'b0;
      exp_q       <= '0;
      exp_addr_q  <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rexp_q     <= rexp_d;
      busy_q     <= busy_d;
      nbart_q    <= busy_d;
      cmp_q      <= rd_q && !kill;
      exp_q      <= rexp_q;
      exp_addr_q <= mem_addr;
      if (go) begin
        bg_q        <= bg;
        done_q      <= 1'b0;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_cnt_q  <= '0;
      end
      if (state_q == ST_DRAIN && !kill) done_q <= 1'b1;
      if (cmp_q && !kill && ramout != exp_q) begin
        fail_q <= 1'b1;
        if (!fail_q) fail_addr_q <= exp_addr_q;
        if (fail_cnt_q != '1)
          fail_cnt_q <= fail_cnt_q + cnt_w'(1);
      end
    end
  end

  // Write strobe is blocked during the reset cycle.
  assign mem_we    = we_q && rst;
  assign mem_wdata = wdata_q;
  assign NbarT     = nbart_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_march_controller.sv
// Scoreboard bench for march_controller with a synchronous RAM.
// Driver queues expected ops/results; negedge monitor checks them.
module tb_march_controller;

  localparam int SZ = 6;
  localparam int LEN = 8;
  localparam int CW = 8;
  localparam int N = 64;

  logic           clk = 1'b0;
  logic           rst, start, abort;
  logic [LEN-1:0] bg;
  logic [LEN-1:0] ramout = '0;
  logic           NbarT, mem_we, busy, done, fail;
  logic [SZ-1:0]  mem_addr, fail_addr;
  logic [LEN-1:0] mem_wdata;
  logic [CW-1:0]  fail_cnt;

  always #5 clk = ~clk;

  march_controller #(.size(SZ), .length(LEN), .cnt_w(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bg(bg), .ramout(ramout), .NbarT(NbarT),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_cnt(fail_cnt)
  );

  logic [LEN-1:0] mem [N];
  logic           fault_en = 1'b0;

  always @(posedge clk) begin
    if (NbarT && mem_we) mem[mem_addr] <= mem_wdata;
    ramout <= mem[mem_addr] |
      ((fault_en && mem_addr == 6'h2A) ? 8'h08 : 8'h00);
  end

  typedef struct {
    logic [SZ-1:0]  addr;
    logic           we;
    logic [LEN-1:0] wd;
    logic           drain;
  } op_t;

  typedef struct {
    logic          done;
    logic          fail;
    logic [SZ-1:0] fa;
    logic [CW-1:0] fc;
    int            cycles;
  } res_t;

  op_t  opq[$];
  res_t resq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   bn = 0;
  int   stray = 0;
  logic pb = 1'b0;
  logic [SZ-1:0] trace [700];
  op_t  e_op;
  res_t e_res;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(int a, logic w, logic [LEN-1:0] d,
                             logic dr);
    op_t o;
    o.addr = SZ'(a);
    o.we = w;
    o.wd = d;
    o.drain = dr;
    return o;
  endfunction

  task automatic push_ops(input logic [LEN-1:0] b, input int lim);
    op_t l[$];
    for (int a = 0; a < N; a++) l.push_back(mk(a, 1, b, 0));
    for (int a = 0; a < N; a++) begin
      l.push_back(mk(a, 0, 0, 0));
      l.push_back(mk(a, 1, ~b, 0));
    end
    for (int a = 0; a < N; a++) begin
      l.push_back(mk(a, 0, 0, 0));
      l.push_back(mk(a, 1, b, 0));
    end
    for (int a = N - 1; a >= 0; a--) begin
      l.push_back(mk(a, 0, 0, 0));
      l.push_back(mk(a, 1, ~b, 0));
    end
    for (int a = N - 1; a >= 0; a--) begin
      l.push_back(mk(a, 0, 0, 0));
      l.push_back(mk(a, 1, b, 0));
    end
    for (int a = 0; a < N; a++) l.push_back(mk(a, 0, 0, 0));
    l.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < lim; i++) opq.push_back(l[i]);
  endtask

  // Monitor: one queued op per busy cycle, one result per run.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) begin
        n_chk++;
        if (opq.size() == 0) begin
          n_fail++;
          $display("FAIL op[%0d]: unexpected busy cycle", bn);
        end else begin
          e_op = opq.pop_front();
          if (!NbarT || mem_we != e_op.we ||
              (!e_op.drain && mem_addr != e_op.addr) ||
              (e_op.we && mem_wdata != e_op.wd)) begin
            n_fail++;
            $display("FAIL op[%0d]: got a=%0h we=%0b d=%0h nbt=%0b, want a=%0h we=%0b d=%0h",
                     bn, mem_addr, mem_we, mem_wdata, NbarT,
                     e_op.addr, e_op.we, e_op.wd);
          end
        end
        if (bn < 700) trace[bn] = mem_addr;
        bn++;
      end else begin
        if (mem_we) stray++;
        if (pb) begin
          if (resq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL result: no expectation queued");
          end else begin
            e_res = resq.pop_front();
            chk("done", 32'(done), 32'(e_res.done));
            chk("fail", 32'(fail), 32'(e_res.fail));
            chk("fail_addr", 32'(fail_addr), 32'(e_res.fa));
            chk("fail_cnt", 32'(fail_cnt), 32'(e_res.fc));
            chk("busy_cycles", bn, e_res.cycles);
            chk("ops_left", opq.size(), 0);
            chk("nbart_idle", 32'(NbarT), 0);
          end
          bn = 0;
        end
      end
      pb = busy;
    end
  end

  task automatic outs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_nbart"}, 32'(NbarT), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_faddr"}, 32'(fail_addr), 0);
    chk({tag, "_fcnt"}, 32'(fail_cnt), 0);
  endtask

  // kind 0: full run, 1: abort at cycle 'at', 2: reset at 'at'
  task automatic run_test(input logic [LEN-1:0] b, input logic f,
                          input int kind, input int at,
                          input logic xf, input logic [SZ-1:0] xa,
                          input logic [CW-1:0] xc);
    res_t r;
    int   lim;
    int   n;
    logic fin;
    fault_en = f;
    lim = (kind == 0) ? 641 : ((kind == 1) ? at : at - 1);
    push_ops(b, lim);
    r.done = (kind == 0);
    r.fail = xf;
    r.fa = xa;
    r.fc = xc;
    r.cycles = lim;
    resq.push_back(r);
    @(posedge clk); #1;
    start = 1'b1;
    bg = b;
    @(posedge clk); #1;
    start = 1'b0;
    bg = ~b;
    n = 1;
    fin = 1'b0;
    for (int g = 0; g < 1000 && !fin; g++) begin
      if (!busy) begin
        fin = 1'b1;
      end else begin
        if (kind == 0 && n == 100) start = 1'b1;
        if (kind == 1 && n == at) abort = 1'b1;
        if (kind == 2 && n == at) begin
          rst = 1'b0;
          start = 1'b1;
          abort = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        rst = 1'b1;
        if (kind == 2 && n == at) outs_zero("rst_mid");
        n++;
      end
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: busy=%0b after %0d cycles", busy, n);
    end
    @(negedge clk); #1;
    chk("result_popped", resq.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    outs_zero("reset");

    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_nbart", 32'(NbarT), 0);

    run_test(8'h00, 1'b0, 0, 0, 1'b0, 6'h00, 8'd0);
    chk("m3_first_addr", 32'(trace[320]), 32'h3F);
    chk("m4_last_addr", 32'(trace[575]), 32'h00);
    chk("m5_first_addr", 32'(trace[576]), 32'h00);

    run_test(8'h00, 1'b1, 0, 0, 1'b1, 6'h2A, 8'd3);
    run_test(8'hA5, 1'b0, 0, 0, 1'b0, 6'h00, 8'd0);

    stray = 0;
    run_test(8'h3C, 1'b0, 1, 200, 1'b0, 6'h00, 8'd0);
    repeat (3) @(posedge clk);
    chk("abort_no_writes", stray, 0);
    run_test(8'h3C, 1'b0, 0, 0, 1'b0, 6'h00, 8'd0);

    run_test(8'h00, 1'b0, 2, 200, 1'b0, 6'h00, 8'd0);
    chk("rst_mem3_kept", 32'(mem[3]), 32'hFF);
    @(posedge clk); #1;
    chk("rst_stays_idle", 32'(busy), 0);
    chk("final_no_stray", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
